// File: rtl/weight_pkg.sv
// Shared definitions for the Maxnet weight buffer: geometry, default pattern and loader state encoding.
// The optional WEIGHT_READBACK_EN macro is consumed by weight_buffer_loader, not by this package.
package weight_pkg;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int COUNT_W = 5;

    localparam logic [WIDTH-1:0] ONE          = 32'h3F80_0000;
    localparam logic [WIDTH-1:0] MINUSEPSILON = 32'hBE4C_CCCD;

    typedef enum logic {
        DONE = 1'b0,
        LOAD = 1'b1
    } load_state_t;

    // Diagonal of the 4x4 matrix (entries 0, 5, 10, 15) is 1.0, everything else is -0.2.
    function automatic logic [WIDTH-1:0] default_weight(input int i);
        return ((i % 5) == 0) ? ONE : MINUSEPSILON;
    endfunction

endpackage

// File: rtl/weight_loader_ctrl.sv
// Load sequencer for the weight buffer: tracks the DONE/LOAD state and the word count,
// and tells the storage array when and where to write.
module weight_loader_ctrl
    import weight_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               load_done,
    output logic [COUNT_W-1:0] load_count,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr
);

    load_state_t        state;
    load_state_t        state_next;
    logic [COUNT_W-1:0] count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DONE;
            load_count <= '0;
        end else begin
            state      <= state_next;
            load_count <= count_next;
        end
    end

    // A start in LOAD restarts the count and suppresses any handshake in that cycle.
    always_comb begin
        state_next = state;
        count_next = load_count;
        in_ready   = 1'b0;
        load_done  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = load_count[ADDR_W-1:0];

        case (state)
            DONE: begin
                load_done = 1'b1;
                if (start) begin
                    state_next = LOAD;
                    count_next = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (start) begin
                    count_next = '0;
                end else if (in_valid) begin
                    wr_en      = 1'b1;
                    count_next = load_count + 5'd1;
                    if (load_count == COUNT_W'(DEPTH - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next = DONE;
            end
        endcase
    end

endmodule

// File: rtl/weight_buffer_loader.sv
// Writable 16x32 Maxnet weight store, loaded serially in row-major order and presented in parallel.
// Define WEIGHT_READBACK_EN to add a registered single-entry readback port (rd_addr/rd_data).
module weight_buffer_loader
    import weight_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
`ifdef WEIGHT_READBACK_EN
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [WIDTH-1:0]       rd_data,
`endif
    output logic [DEPTH*WIDTH-1:0] out,
    output logic [COUNT_W-1:0]     load_count,
    output logic                   load_done
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  entries [DEPTH];

    weight_loader_ctrl u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load_done  (load_done),
        .load_count (load_count),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr)
    );

    // Reset reloads the default Maxnet pattern so the network works without any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= default_weight(i);
            end
        end else if (wr_en) begin
            entries[wr_addr] <= in_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign out[g*WIDTH +: WIDTH] = entries[g];
    end

`ifdef WEIGHT_READBACK_EN
    // Sampling the array with a non-blocking read returns the pre-write value on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= entries[rd_addr];
        end
    end
`endif

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Self-checking bench for weight_buffer_loader: directed load scenarios plus a randomized phase,
// compared every cycle against a behavioural model of the buffer (readback checked when WEIGHT_READBACK_EN is set).
module tb_weight_buffer_loader;

    localparam logic [31:0] W_ONE = 32'h3F80_0000;
    localparam logic [31:0] W_NEG = 32'hBE4C_CCCD;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [511:0] out;
    logic [4:0]   load_count;
    logic         load_done;
`ifdef WEIGHT_READBACK_EN
    logic [3:0]   rd_addr;
    logic [31:0]  rd_data;
    logic [31:0]  exp_rd;
    logic [31:0]  old_val;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [16];
    int unsigned ref_count;
    bit          ref_loading;

    always #5 clk = ~clk;

    weight_buffer_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef WEIGHT_READBACK_EN
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
`endif
        .out        (out),
        .load_count (load_count),
        .load_done  (load_done)
    );

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] refVector();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = ref_mem[i];
        return v;
    endfunction

    // Default matrix: 1.0 where row == column, -0.2 elsewhere.
    task automatic modelReset();
        for (int i = 0; i < 16; i++) ref_mem[i] = ((i / 4) == (i % 4)) ? W_ONE : W_NEG;
        ref_count   = 0;
        ref_loading = 0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ":out"}, out, refVector());
        checkOutput({tag, ":load_count"}, 512'(load_count), 512'(ref_count));
        checkOutput({tag, ":load_done"}, 512'(load_done), 512'(!ref_loading));
        checkOutput({tag, ":in_ready"}, 512'(in_ready), 512'(ref_loading));
`ifdef WEIGHT_READBACK_EN
        checkOutput({tag, ":rd_data"}, 512'(rd_data), 512'(exp_rd));
`endif
    endtask

    // Drive one cycle, advance the model by the behavioural rules, then check #1 after the edge.
    task automatic applyStimulus(input logic s, input logic v, input logic [31:0] d,
                                 input logic r, input string tag);
        rst      = r;
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
`ifdef WEIGHT_READBACK_EN
        exp_rd = r ? 32'h0 : ref_mem[rd_addr];
`endif
        if (r) begin
            modelReset();
        end else if (ref_loading) begin
            if (s) begin
                ref_count = 0;
            end else if (v) begin
                ref_mem[ref_count] = d;
                ref_count++;
                if (ref_count == 16) ref_loading = 0;
            end
        end else if (s) begin
            ref_loading = 1;
            ref_count   = 0;
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        logic r, s, v;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef WEIGHT_READBACK_EN
        rd_addr  = '0;
        exp_rd   = '0;
`endif
        modelReset();

        $display("[TB] reset");
        applyStimulus(0, 0, 32'h0, 1, "reset0");
        applyStimulus(1, 1, 32'h1234_5678, 1, "reset1");
        checkOutput("reset:entry0", 512'(out[31:0]), 512'(32'h3F80_0000));
        checkOutput("reset:entry1", 512'(out[63:32]), 512'(32'hBE4C_CCCD));
        checkOutput("reset:entry15", 512'(out[511:480]), 512'(32'h3F80_0000));
        applyStimulus(0, 0, 32'h0, 0, "idle");

        $display("[TB] full load");
        applyStimulus(1, 0, 32'h0, 0, "full:start");
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 32'h4000_0000 + i, 0, $sformatf("full:w%0d", i));
        checkOutput("full:count16", 512'(load_count), 512'(16));
        checkOutput("full:done", 512'(load_done), 512'(1));
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("full:entry%0d", i), 512'(out[i*32 +: 32]), 512'(32'h4000_0000 + i));

        $display("[TB] overrun");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("overrun%0d", i));

        $display("[TB] stalled load");
        applyStimulus(1, 0, 32'h0, 0, "stall:start");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("stall:a%0d", i));
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, $urandom, 0, $sformatf("stall:gap%0d", i));
        checkOutput("stall:count5", 512'(load_count), 512'(5));
        for (int i = 0; i < 11; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("stall:b%0d", i));

        $display("[TB] restart");
        applyStimulus(1, 0, 32'h0, 0, "restart:start");
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("restart:a%0d", i));
        applyStimulus(1, 1, 32'hDEAD_BEEF, 0, "restart:pulse");
        checkOutput("restart:count0", 512'(load_count), 512'(0));
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("restart:b%0d", i));

        $display("[TB] reset mid-load");
        applyStimulus(1, 0, 32'h0, 0, "midrst:start");
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("midrst:w%0d", i));
        checkOutput("midrst:count9", 512'(load_count), 512'(9));
        applyStimulus(1, 1, $urandom, 1, "midrst:reset");

`ifdef WEIGHT_READBACK_EN
        $display("[TB] readback");
        applyStimulus(1, 0, 32'h0, 0, "rb:start");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("rb:w%0d", i));
        rd_addr = 4'd3;
        old_val = ref_mem[3];
        applyStimulus(0, 1, 32'h3F00_0000, 0, "rb:collide");
        checkOutput("rb:old", 512'(rd_data), 512'(old_val));
        applyStimulus(0, 0, 32'h0, 0, "rb:read");
        checkOutput("rb:new", 512'(rd_data), 512'(32'h3F00_0000));
        for (int i = 4; i < 16; i++) applyStimulus(0, 1, $urandom, 0, $sformatf("rb:w%0d", i));
`endif

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 3) != 0);
`ifdef WEIGHT_READBACK_EN
            rd_addr = 4'($urandom_range(0, 15));
`endif
            applyStimulus(s, v, $urandom, r, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
